// File: rtl/image_link_pkg.sv
// Shared definitions for the UART image link (sender and receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package image_link_pkg;

    typedef enum logic [2:0] {
        ST_RDY       = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CHECK     = 3'd4,
        ST_EMIT      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam int BYTES_PER_PIXEL = 5;

    localparam logic [2:0] IDX_RED   = 3'd0;
    localparam logic [2:0] IDX_GREEN = 3'd1;
    localparam logic [2:0] IDX_BLUE  = 3'd2;
    localparam logic [2:0] IDX_H     = 3'd3;
    localparam logic [2:0] IDX_V     = 3'd4;

    // Keeps degenerate dimensions (e.g. a single-line frame) at a legal 1-bit width.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y counter: x wraps at WIDTH-1 and carries into y; flags the last pixel.
// Latency: counts update one cycle after advance/clear.
// Backpressure: counts hold whenever advance is low.
module pixel_coord_counter
    import image_link_pkg::*;
#(
    parameter  int WIDTH  = 640,
    parameter  int HEIGHT = 480,
    localparam int XW     = coord_w(WIDTH),
    localparam int YW     = coord_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_last;
    logic y_last;

    assign x_last = (x == XW'(WIDTH - 1));
    assign y_last = (y == YW'(HEIGHT - 1));
    assign last   = x_last && y_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_receiver.sv
// Drains UART bytes, rebuilds 5-byte pixel records and emits one pixel per record.
// Latency: 17 cycles per pixel best case (3 per byte, then CHECK and EMIT).
// Backpressure: holds in EMIT with stable outputs and pops no bytes while pix_ready=0.
module image_receiver
    import image_link_pkg::*;
#(
    parameter  int WIDTH  = 640,
    parameter  int HEIGHT = 480,
    localparam int XW     = coord_w(WIDTH),
    localparam int YW     = coord_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          rdy,
    input  logic          en,
    input  logic [7:0]    rx_data,
    input  logic          rx_empty,
    output logic          rx_enable,
    output logic          uld_rx_data,
    output logic [7:0]    pix_red,
    output logic [7:0]    pix_green,
    output logic [7:0]    pix_blue,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          frame_done,
    output logic          seq_err
);

    state_t     state;
    logic [2:0] byte_idx;
    logic [7:0] h_byte;
    logic [7:0] v_byte;
    logic       cnt_clear;
    logic       cnt_advance;
    logic       cnt_last;

    assign cnt_clear   = (state == ST_RDY) && en;
    assign cnt_advance = (state == ST_EMIT) && pix_ready;

    pixel_coord_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .x       (pix_x),
        .y       (pix_y),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RDY;
            byte_idx  <= '0;
            pix_red   <= '0;
            pix_green <= '0;
            pix_blue  <= '0;
            h_byte    <= '0;
            v_byte    <= '0;
            seq_err   <= 1'b0;
        end else begin
            case (state)
                ST_RDY: begin
                    if (en) begin
                        byte_idx <= '0;
                        seq_err  <= 1'b0;
                        state    <= ST_WAIT_BYTE;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (!rx_empty) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    case (byte_idx)
                        IDX_RED:   pix_red   <= rx_data;
                        IDX_GREEN: pix_green <= rx_data;
                        IDX_BLUE:  pix_blue  <= rx_data;
                        IDX_H:     h_byte    <= rx_data;
                        IDX_V:     v_byte    <= rx_data;
                        default:   ;
                    endcase
                    byte_idx <= byte_idx + 3'd1;
                    state    <= ST_SETTLE;
                end
                // One idle cycle lets the UART core retire the popped byte before rx_empty is trusted.
                ST_SETTLE: begin
                    if (byte_idx == 3'(BYTES_PER_PIXEL)) begin
                        byte_idx <= '0;
                        state    <= ST_CHECK;
                    end else begin
                        state <= ST_WAIT_BYTE;
                    end
                end
                ST_CHECK: begin
                    if ((h_byte != 8'(pix_x)) || (v_byte != 8'(pix_y))) seq_err <= 1'b1;
                    state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (pix_ready) state <= cnt_last ? ST_DONE : ST_WAIT_BYTE;
                end
                ST_DONE: begin
                    if (!en) state <= ST_RDY;
                end
                default: state <= ST_RDY;
            endcase
        end
    end

    assign rdy         = (state == ST_RDY);
    assign rx_enable   = (state != ST_RDY) && (state != ST_DONE);
    assign uld_rx_data = (state == ST_CAPTURE);
    assign pix_valid   = (state == ST_EMIT);
    assign frame_done  = (state == ST_DONE);

endmodule

// File: tb/tb_image_receiver.sv
// Bench for image_receiver on a 10x1 frame: table vectors, hand-written corner sequences and randomized frames.
module tb_image_receiver;

    localparam int W = 10;
    localparam int H = 1;

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic       en;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_enable;
    logic       uld_rx_data;
    logic [7:0] pix_red;
    logic [7:0] pix_green;
    logic [7:0] pix_blue;
    logic [3:0] pix_x;
    logic [0:0] pix_y;
    logic       pix_valid;
    logic       pix_ready;
    logic       frame_done;
    logic       seq_err;

    image_receiver #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .en          (en),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_enable   (rx_enable),
        .uld_rx_data (uld_rx_data),
        .pix_red     (pix_red),
        .pix_green   (pix_green),
        .pix_blue    (pix_blue),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_done  (frame_done),
        .seq_err     (seq_err)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [3:0] x;
        logic [0:0] y;
    } pix_t;

    typedef struct packed {
        logic [7:0] r_in;
        logic [7:0] g_in;
        logic [7:0] b_in;
        logic [7:0] h_in;
        logic [7:0] v_in;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
        logic [7:0] exp_b;
        logic [3:0] exp_x;
        logic       exp_seq;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] feed[$];
    pix_t       got[$];
    int         uld_total = 0;
    bit         rand_ready = 0;
    bit         gap_rand = 0;
    bit         ready_force = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART core model: pops on uld_rx_data, then reports empty for a gap before the next byte.
    initial begin
        bit pend;
        bit prev_uld;
        int gap;
        prev_uld = 0;
        gap = 0;
        rx_empty = 1'b1;
        rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (uld_rx_data) begin
                uld_total++;
                check("uld_while_empty", 32'(rx_empty), 32'd0);
                check("uld_back_to_back", 32'(prev_uld), 32'd0);
            end
            pend = uld_rx_data;
            prev_uld = uld_rx_data;
            @(posedge clk);
            #1;
            if (pend && feed.size() > 0) begin
                void'(feed.pop_front());
                gap = gap_rand ? int'($urandom_range(0, 2)) : 1;
            end
            if (gap > 0) begin
                gap--;
                rx_empty = 1'b1;
                rx_data = 8'($urandom);
            end else if (feed.size() > 0) begin
                rx_empty = 1'b0;
                rx_data = feed[0];
            end else begin
                rx_empty = 1'b1;
                rx_data = 8'($urandom);
            end
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Pixel monitor: collects accepted pixels and checks stability across stalls.
    initial begin
        pix_t cur;
        pix_t snap;
        bit   stalled;
        stalled = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            cur = '{r: pix_red, g: pix_green, b: pix_blue, x: pix_x, y: pix_y};
            if (stalled && pix_valid) check("stall_stable", 32'(cur), 32'(snap));
            if (pix_valid && pix_ready) got.push_back(cur);
            stalled = pix_valid && !pix_ready;
            snap = cur;
        end
    end

    task automatic push_rec(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] h, input logic [7:0] v);
        feed.push_back(r);
        feed.push_back(g);
        feed.push_back(b);
        feed.push_back(h);
        feed.push_back(v);
    endtask

    task automatic wait_pixel(output pix_t p);
        int n;
        n = 0;
        while (got.size() == 0 && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (got.size() == 0) begin
            failures++;
            $display("FAIL pixel_timeout actual=no_pixel required=pixel (t=%0t)", $time);
            p = '0;
        end else begin
            p = got.pop_front();
        end
    endtask

    task automatic wait_uld(input int target);
        int n;
        n = 0;
        while (uld_total < target && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("uld_reached", 32'(uld_total >= target), 32'd1);
    endtask

    task automatic cmp_pix(input pix_t p, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic [3:0] x, input logic [0:0] y);
        check("pix_red", 32'(p.r), 32'(r));
        check("pix_green", 32'(p.g), 32'(g));
        check("pix_blue", 32'(p.b), 32'(b));
        check("pix_x", 32'(p.x), 32'(x));
        check("pix_y", 32'(p.y), 32'(y));
    endtask

    task automatic start_frame();
        int n;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before_en", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl[W];
        logic [7:0] recs[W][5];
        pix_t       p;
        int         base;
        int         bad;
        bit         exp_seq;
        bit         saw_uld;
        bit         left_wait;
        int         n;

        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_rx_enable", 32'(rx_enable), 32'd0);
        check("rst_uld", 32'(uld_rx_data), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'({pix_red, pix_green, pix_blue}), 32'd0);
        check("rst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: table-driven records (i, i+1, i+2, i, 0)
        for (int i = 0; i < W; i++) begin
            tbl[i].r_in = 8'(i);
            tbl[i].g_in = 8'(i + 1);
            tbl[i].b_in = 8'(i + 2);
            tbl[i].h_in = 8'(i);
            tbl[i].v_in = 8'd0;
            tbl[i].exp_r = 8'(i);
            tbl[i].exp_g = 8'(i + 1);
            tbl[i].exp_b = 8'(i + 2);
            tbl[i].exp_x = 4'(i);
            tbl[i].exp_seq = 1'b0;
        end
        base = uld_total;
        start_frame();
        for (int i = 0; i < W; i++)
            push_rec(tbl[i].r_in, tbl[i].g_in, tbl[i].b_in, tbl[i].h_in, tbl[i].v_in);
        for (int i = 0; i < W; i++) begin
            wait_pixel(p);
            cmp_pix(p, tbl[i].exp_r, tbl[i].exp_g, tbl[i].exp_b, tbl[i].exp_x, 1'b0);
            check("tbl_seq_err", 32'(seq_err), 32'(tbl[i].exp_seq));
        end
        @(negedge clk);
        check("f1_frame_done", 32'(frame_done), 32'd1);
        check("f1_seq_err", 32'(seq_err), 32'd0);
        check("f1_uld_count", 32'(uld_total - base), 32'd50);

        // Frame 2: starvation mid-record, EMIT stall, H mismatch on pixel 2
        base = uld_total;
        start_frame();
        push_rec(8'h10, 8'h20, 8'h30, 8'h00, 8'h00);
        void'(feed.pop_back());
        void'(feed.pop_back());
        void'(feed.pop_back());
        wait_uld(base + 2);
        repeat (3) @(negedge clk);
        check("starve_state", 32'(dut.state), 32'd1);
        saw_uld = 0;
        left_wait = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uld_rx_data) saw_uld = 1;
            if (dut.state != 3'd1) left_wait = 1;
        end
        check("starve_no_uld", 32'(saw_uld), 32'd0);
        check("starve_left_wait", 32'(left_wait), 32'd0);
        check("starve_rx_enable", 32'(rx_enable), 32'd1);
        ready_force = 0;
        feed.push_back(8'h30);
        feed.push_back(8'h00);
        feed.push_back(8'h00);
        n = 0;
        while (!pix_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 8; c++) begin
            check("stall_valid", 32'(pix_valid), 32'd1);
            check("stall_no_uld", 32'(uld_rx_data), 32'd0);
            check("stall_data", 32'({pix_red, pix_green, pix_blue, pix_x}), {8'h10, 8'h20, 8'h30, 4'h0});
            @(negedge clk);
        end
        ready_force = 1;
        wait_pixel(p);
        cmp_pix(p, 8'h10, 8'h20, 8'h30, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("stall_single_accept", 32'(got.size()), 32'd0);
        check("stall_valid_dropped", 32'(pix_valid), 32'd0);
        for (int i = 1; i < W; i++)
            push_rec(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), (i == 2) ? 8'd7 : 8'(i), 8'd0);
        for (int i = 1; i < W; i++) begin
            wait_pixel(p);
            cmp_pix(p, 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 4'(i), 1'b0);
            if (i == 1) check("seq_before_bad", 32'(seq_err), 32'd0);
            if (i == 2) check("seq_after_bad", 32'(seq_err), 32'd1);
        end
        @(negedge clk);
        check("f2_frame_done", 32'(frame_done), 32'd1);
        check("f2_seq_sticky", 32'(seq_err), 32'd1);
        check("f2_uld_count", 32'(uld_total - base), 32'd50);

        // Frame 3: seq_err clears on start, then reset after 3 bytes
        base = uld_total;
        start_frame();
        @(negedge clk);
        check("seq_cleared", 32'(seq_err), 32'd0);
        push_rec(8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00);
        void'(feed.pop_back());
        void'(feed.pop_back());
        wait_uld(base + 3);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(dut.state), 32'd0);
        check("mid_rst_rdy", 32'(rdy), 32'd1);
        check("mid_rst_outs", 32'({rx_enable, uld_rx_data, pix_valid, frame_done, seq_err}), 32'd0);
        check("mid_rst_pix", 32'({pix_red, pix_green, pix_blue, pix_x, pix_y}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized frames against the reference model
        rand_ready = 1;
        gap_rand = 1;
        for (int f = 0; f < 3; f++) begin
            bad = int'($urandom_range(0, 2 * W - 1));
            exp_seq = 0;
            for (int i = 0; i < W; i++) begin
                recs[i][0] = 8'($urandom);
                recs[i][1] = 8'($urandom);
                recs[i][2] = 8'($urandom);
                recs[i][3] = 8'(i % W);
                recs[i][4] = 8'(i / W);
                if (i == bad) begin
                    if ($urandom_range(0, 1) == 0) recs[i][3] = recs[i][3] ^ 8'($urandom_range(1, 255));
                    else recs[i][4] = recs[i][4] ^ 8'($urandom_range(1, 255));
                    exp_seq = 1;
                end
            end
            base = uld_total;
            start_frame();
            for (int i = 0; i < W; i++)
                push_rec(recs[i][0], recs[i][1], recs[i][2], recs[i][3], recs[i][4]);
            for (int i = 0; i < W; i++) begin
                wait_pixel(p);
                cmp_pix(p, recs[i][0], recs[i][1], recs[i][2], 4'(i % W), 1'(i / W));
            end
            @(negedge clk);
            check("rnd_frame_done", 32'(frame_done), 32'd1);
            check("rnd_seq_err", 32'(seq_err), 32'(exp_seq));
            check("rnd_uld_count", 32'(uld_total - base), 32'd50);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
# image_receiver

Receive-side counterpart of the UART image sender. It drains 8-bit bytes from a UART receiver core, reassembles each 5-byte pixel record (Red, Green, Blue, H_cont, V_cont) and presents one pixel per record on a valid/ready output for a frame-buffer writer. It checks each record's coordinate bytes against its own raster counters. It runs one frame per rdy/en handshake, on the PC-link side of the design.

## Interface
Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- rdy  out  1  high while idle and able to accept en
- en  in  1  start one frame; sampled only while rdy=1
- rx_data  in  8  byte from UART core; valid while rx_empty=0
- rx_empty  in  1  1 = UART core holds no unread byte
- rx_enable  out  1  enables UART core reception
- uld_rx_data  out  1  one-cycle pulse that pops the current byte
- pix_red, pix_green, pix_blue  out  8 each  reassembled colour
- pix_x  out  clog2(WIDTH)  column from internal counter
- pix_y  out  clog2(HEIGHT)  row from internal counter
- pix_valid  out  1  pixel record available
- pix_ready  in  1  sink accepts the pixel when pix_valid=1
- frame_done  out  1  high in DONE
- seq_err  out  1  sticky coordinate-mismatch flag for the current frame

## Operation
- States and encoding: RDY=0, WAIT_BYTE=1, CAPTURE=2, SETTLE=3, CHECK=4, EMIT=5, DONE=6.
- RDY:
  - rdy=1.
  - On en=1: clear x_cnt, y_cnt, byte_idx and seq_err, then go to WAIT_BYTE.
- WAIT_BYTE: if rx_empty=0, go to CAPTURE; otherwise stay.
- CAPTURE:
  - Latch rx_data into slot byte_idx (0=R, 1=G, 2=B, 3=H, 4=V).
  - Pulse uld_rx_data=1 and increment byte_idx.
  - Go to SETTLE.
- SETTLE:
  - Exists so that rx_empty can update after the pop.
  - If byte_idx==5: clear byte_idx and go to CHECK. Otherwise go to WAIT_BYTE.
- CHECK:
  - If H byte != x_cnt[7:0] or V byte != y_cnt[7:0], set seq_err (sticky until the next en in RDY).
  - The record is still emitted with counter coordinates.
  - Go to EMIT.
- EMIT:
  - pix_valid=1 with outputs held stable until pix_ready=1.
  - On handshake, advance the counters. x_cnt wraps to 0 at WIDTH-1 and y_cnt increments at the same time.
  - On handshake: if the pixel was (WIDTH-1, HEIGHT-1), go to DONE; otherwise go to WAIT_BYTE.
- DONE:
  - frame_done=1.
  - Stay while en=1. When en=0, go to RDY.
- rx_enable=1 in WAIT_BYTE, CAPTURE, SETTLE, CHECK and EMIT; 0 in RDY and DONE.
- Coordinate comparison uses only the low 8 bits, because the sender transmits 8-bit H_cont/V_cont.
- en is ignored outside RDY. A mid-frame abort happens only through reset.

## Timing
- Reset (asynchronous, any state):
  - state goes to RDY.
  - rdy=1 and every other output is 0: rx_enable, uld_rx_data, pix_* data/valid, frame_done, seq_err.
  - Counters and byte_idx clear.
  - Any partial record is discarded.
- All outputs decode from registered state and registers. No combinational path from inputs to outputs.
- Best case per pixel, with rx_empty=0 throughout and pix_ready=1: 5×3 + CHECK + EMIT = 17 cycles.
- uld_rx_data:
  - Exactly one cycle per byte, never in consecutive cycles.
  - Never asserted while rx_empty=1.
- A byte present in the same cycle that the FSM enters WAIT_BYTE is captured on the next edge.
- Backpressure: with pix_ready=0, the FSM stays in EMIT indefinitely and pops no further bytes.
- A frame of WIDTH×HEIGHT records ends in DONE; frame_done rises the cycle after the last handshake.

## Structure
- Package image_link_pkg holds:
  - the state enum with the encodings above;
  - BYTES_PER_PIXEL=5;
  - slot indices IDX_RED=0, IDX_GREEN=1, IDX_BLUE=2, IDX_H=3, IDX_V=4.
  - The sender imports the same package.
- One sub-module, pixel_coord_counter: raster x/y counter with advance input, WIDTH/HEIGHT wrap and a last-pixel flag.

## Test plan
Bench configuration: WIDTH=10, HEIGHT=1.
1. Reset, then en=1. Feed bytes (i, i+1, i+2, i, 0) for i=0..9 with rx_empty toggling per byte and pix_ready=1.
   - Ten pix_valid handshakes with red=i, green=i+1, blue=i+2, pix_x=i.
   - seq_err=0 and frame_done=1 after the 10th pixel.
2. Hold rx_empty=1 for 20 cycles mid-record.
   - FSM stays in WAIT_BYTE (1) with no uld_rx_data.
   - Resumes correctly once rx_empty=0.
3. Hold pix_ready=0 for 8 cycles in EMIT.
   - pix_valid stays 1 and pixel data is stable; no uld_rx_data pulses.
   - A single pixel is accepted when pix_ready rises.
4. Send H byte 7 on the record for pixel 2.
   - seq_err rises after CHECK and stays 1 through DONE.
   - Pixel is emitted with pix_x=2.
   - seq_err clears on the next frame start.
5. Assert rst_n=0 after 3 bytes of a record.
   - All outputs take reset values and state=RDY.
   - The next frame starts with byte_idx=0 and pix_x=0.
6. Count uld_rx_data pulses over a full frame: exactly 50, and none while rx_empty=1.
